// File: rtl/fifo_pixel_packer.sv
// Drains bytes from the pixel FIFO, packs Pack of them per word (first byte in lane 0) and
// hands each word to the NPU input stage over valid/ready, flagging the last word of an image.
module fifo_pixel_packer #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned Pack      = 4,
  parameter int unsigned ImgPixels = 784,
  localparam int unsigned NumWords = ImgPixels / Pack,
  localparam int unsigned IdxW     = (NumWords > 1) ? $clog2(NumWords) : 1
) (
  input  logic                      clkext_i,
  input  logic                      rst_ni,
  input  logic                      clr_i,
  input  logic                      fifo_empty_i,
  output logic                      fifo_rd_en_o,
  input  logic [DataWidth-1:0]      fifo_data_i,
  output logic [Pack*DataWidth-1:0] out_data_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic                      out_last_o,
  output logic [IdxW-1:0]           word_idx_o
);

  localparam int unsigned CntW = $clog2(Pack + 1);
  localparam logic [CntW-1:0] PackCnt  = CntW'(Pack);
  localparam logic [CntW:0]   PackWide = (CntW + 1)'(Pack);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NumWords - 1);

  typedef enum logic [0:0] {StFill, StEmit} state_e;

  state_e                    state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic                      pend_q, pend_d;
  logic [Pack*DataWidth-1:0] lanes_q, lanes_d;
  logic [IdxW-1:0]           idx_q, idx_d;
  logic [CntW:0]             fill_level;
  logic                      rd_en;

  // Lanes already captured plus the one in flight must leave room for another read.
  assign fill_level = {1'b0, cnt_q} + {{CntW{1'b0}}, pend_q};
  assign rd_en = rst_ni & ~clr_i & (state_q == StFill) & ~fifo_empty_i & (fill_level < PackWide);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    lanes_d = lanes_q;
    idx_d   = idx_q;
    if (clr_i) begin
      state_d = StFill;
      cnt_d   = '0;
      pend_d  = 1'b0;
      lanes_d = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        StFill: begin
          pend_d = rd_en;
          if (pend_q) begin
            for (int k = 0; k < Pack; k++) begin
              if (cnt_q == CntW'(k)) lanes_d[k*DataWidth +: DataWidth] = fifo_data_i;
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == PackCnt) state_d = StEmit;
          end
        end
        StEmit: begin
          if (out_ready_i) begin
            state_d = StFill;
            cnt_d   = '0;
            lanes_d = '0;
            idx_d   = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
          end
        end
        default: state_d = StFill;
      endcase
    end
  end

  always_ff @(posedge clkext_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StFill;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      lanes_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      lanes_q <= lanes_d;
      idx_q   <= idx_d;
    end
  end

  assign fifo_rd_en_o = rd_en;
  assign out_valid_o  = (state_q == StEmit);
  assign out_data_o   = lanes_q;
  assign out_last_o   = out_valid_o & (idx_q == LastIdx);
  assign word_idx_o   = idx_q;

endmodule

// File: doc/fifo_pixel_packer.md
# fifo_pixel_packer

Read-side consumer for the pixel input FIFO. Drains bytes from the FIFO's read port, packs PACK consecutive pixels into one wide word (first byte in the lowest lane), and presents it to the NPU input stage over a valid/ready handshake. A word counter marks the final word of each image with OUT_LAST. Sits between the 8-bit pixel FIFO and the NPU's first layer.

## Interface
- DATA_WIDTH, 8, pixel width; must match the FIFO.
- PACK, 4, pixels per output word; ≥2.
- IMG_PIXELS, 784, pixels per image; must be a multiple of PACK (784/4 = 196 words).

- CLKEXT  in  1  single clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- CLR  in  1  synchronous clear: drop partial word and in-flight read, zero word counter.
- FIFO_EMPTY  in  1  FIFO empty flag.
- FIFO_RD_EN  out  1  read strobe to FIFO.
- FIFO_DATA  in  DATA_WIDTH  FIFO read data; valid the cycle after an accepted read.
- OUT_DATA  out  PACK*DATA_WIDTH  packed word; lane k = bits [k*DW +: DW].
- OUT_VALID  out  1  OUT_DATA/OUT_LAST valid.
- OUT_READY  in  1  downstream accepts.
- OUT_LAST  out  1  word is the last of the current image.
- WORD_IDX  out  clog2(IMG_PIXELS/PACK)  index of the word being assembled/presented.

## Operation
- Two states: FILL, EMIT. Reset state FILL.
- Registers: lane count CNT (0..PACK), pending flag PEND (read issued, data not yet captured), lane buffer, WORD_IDX.
- FIFO_RD_EN (combinational) = RST_N & ~CLR & (state==FILL) & ~FIFO_EMPTY & (CNT + PEND < PACK).
- Read issued at edge t sets PEND; at edge t+1 FIFO_DATA is written to lane CNT, CNT increments, PEND clears unless a new read is issued at the same edge. Back-to-back reads allowed: one pixel per cycle.
- FILL → EMIT when CNT reaches PACK (same edge as last capture); OUT_VALID rises.
- EMIT: OUT_VALID=1, OUT_DATA and OUT_LAST held stable; no FIFO reads. On OUT_VALID & OUT_READY at an edge: CNT←0, state←FILL, WORD_IDX increments, wrapping from IMG_PIXELS/PACK−1 to 0.
- OUT_LAST = OUT_VALID & (WORD_IDX == IMG_PIXELS/PACK−1).
- FIFO going empty mid-word: reads stall, partial lanes retained indefinitely; filling resumes when FIFO_EMPTY deasserts. No timeout.
- CLR (sync, priority over all other updates): state←FILL, CNT←0, PEND←0 (in-flight byte discarded, not captured), WORD_IDX←0, OUT_VALID←0. A word in EMIT is dropped even if OUT_READY is high that cycle.
- Lanes not yet filled read as 0 (buffer cleared on handshake and CLR).

## Timing
- Reset (RST_N low, async): FIFO_RD_EN=0, OUT_VALID=0, OUT_DATA=0, OUT_LAST=0, WORD_IDX=0, CNT=0, PEND=0, state FILL. RST_N deassertion mid-word discards everything.
- Latency: FIFO non-empty with ≥PACK entries, reads at edges 0..PACK−1, OUT_VALID high after edge PACK (PACK+1 cycles from first RD_EN).
- Steady-state throughput with OUT_READY=1: one word per PACK+1 cycles (one EMIT cycle per word).
- OUT_READY may be high before OUT_VALID; no combinational path OUT_READY → OUT_VALID or FIFO_RD_EN.
- FIFO_RD_EN depends combinationally on FIFO_EMPTY, CLR, RST_N only among inputs.
- FIFO contract: read accepted only when RD_EN & ~EMPTY; FIFO_DATA registered, valid one cycle later.

## Test plan
- Reset then preload FIFO with A0..A7, OUT_READY=1 -> OUT_DATA=0xA3A2A1A0 valid after edge 4, then 0xA7A6A5A4; FIFO_RD_EN never high while FIFO_EMPTY=1; WORD_IDX 0→1→2.
- Push A0,A1 only, wait 10 cycles, push A2,A3 -> no OUT_VALID while waiting (CNT=2 held), then 0xA3A2A1A0 emitted.
- Fill one word, hold OUT_READY=0 for 5 cycles -> OUT_VALID and OUT_DATA stable, FIFO_RD_EN=0 throughout; release -> single handshake, filling resumes next cycle.
- Stream 784 pixels (value = index mod 256) -> 196 words, OUT_LAST high only on word 195 (0x0F0E0D0C... pattern checked per word), WORD_IDX wraps to 0; next image word 0 has OUT_LAST=0.
- Assert CLR the cycle after a read with CNT=2 -> CNT=0, in-flight byte dropped; next four FIFO bytes B0..B3 form 0xB3B2B1B0, WORD_IDX=0.
- Drop RST_N asynchronously mid-EMIT -> OUT_VALID, OUT_DATA, FIFO_RD_EN go 0 immediately without a clock edge; after release, behaviour matches scenario 1.
